// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: substitutes a 128-bit state BytesPerCycle bytes per clock.
// Define SUBBYTES_INV_EN to add the inv_i port and the inverse S-box (InvSubBytes).
module subbytes_iter #(
    parameter int unsigned BytesPerCycle = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_i,
`ifdef SUBBYTES_INV_EN
    input  logic         inv_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_o
);

    localparam int unsigned NumGroups = 16 / BytesPerCycle;
    localparam int unsigned CntW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int unsigned GroupW    = 8 * BytesPerCycle;

    if (!(BytesPerCycle == 1 || BytesPerCycle == 2 || BytesPerCycle == 4 ||
          BytesPerCycle == 8 || BytesPerCycle == 16)) begin : g_param_check
        $error("subbytes_iter: BytesPerCycle must be 1, 2, 4, 8 or 16");
    end

    // Entry 0 sits in the most significant byte of each table.
    localparam logic [2047:0] SboxFwd = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUBBYTES_INV_EN
    localparam logic [2047:0] SboxInv = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };
`endif

    function automatic logic [7:0] rom_lookup(input logic [2047:0] rom, input logic [7:0] x);
        return rom[8 * (255 - int'(x)) +: 8];
    endfunction

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [127:0]      data_q, data_d;
    logic [GroupW-1:0] grp_in, grp_out;
    logic              accept;
`ifdef SUBBYTES_INV_EN
    logic              inv_q, inv_d;
`endif

    assign grp_in = data_q[GroupW * cnt_q +: GroupW];

    always_comb begin
        grp_out = '0;
        for (int l = 0; l < int'(BytesPerCycle); l++) begin
`ifdef SUBBYTES_INV_EN
            grp_out[8*l +: 8] = inv_q ? rom_lookup(SboxInv, grp_in[8*l +: 8])
                                      : rom_lookup(SboxFwd, grp_in[8*l +: 8]);
`else
            grp_out[8*l +: 8] = rom_lookup(SboxFwd, grp_in[8*l +: 8]);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef SUBBYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef SUBBYTES_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef SUBBYTES_INV_EN
        inv_d   = inv_q;
`endif
        accept  = in_valid_i && in_ready_o;
        case (state_q)
            StBusy: begin
                data_d[GroupW * cnt_q +: GroupW] = grp_out;
                if (cnt_q == CntW'(NumGroups - 1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase
        // A capture in DONE retires the current word on the same edge.
        if (accept) begin
            state_d = StBusy;
            cnt_d   = '0;
            data_d  = in_i;
`ifdef SUBBYTES_INV_EN
            inv_d   = inv_i;
`endif
        end
    end

    always_comb begin
        in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
        out_valid_o = (state_q == StDone);
        out_o       = out_valid_o ? data_q : '0;
    end

endmodule

// File: tb/tb_subbytes_iter.sv
// Scoreboard bench for subbytes_iter at every legal BytesPerCycle, against an S-box model
// derived from GF(2^8) inversion plus the affine map (inverse tests need SUBBYTES_INV_EN).
module tb_subbytes_iter;

    localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FipsOut = 128'hd42711aee0bf98f1b8b45de51e415230;

    typedef struct {
        logic [127:0] exp;
        int           acc;
    } exp_t;

    logic       clk;
    int         vectors     = 0;
    int         miscompares = 0;
    int         done_cnt    = 0;
    bit         tables_ready = 0;
    logic [7:0] sb_f [256];
    logic [7:0] sb_i [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box = affine(GF inverse); the inverse table is the permutation inverse.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv, s, r;
            iv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            end
            s = iv;
            r = iv;
            for (int k = 1; k <= 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            s = s ^ 8'h63;
            sb_f[x] = s;
            sb_i[s] = 8'(x);
        end
        tables_ready = 1;
    end

    function automatic logic [127:0] subst(input logic [127:0] v, input bit inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv ? sb_i[v[8*k +: 8]] : sb_f[v[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    for (genvar gi = 0; gi < 5; gi++) begin : g_b
        localparam int unsigned B = 1 << gi;
        localparam int          N = 16 / B;

        logic         rst, in_valid, in_ready, out_valid, out_ready, inv;
        logic [127:0] din, dout, held;
        exp_t         sb_q [$];
        int           cyc = 0;
        bit           seen = 0, hold = 0, rand_rdy = 0;

        subbytes_iter #(.BytesPerCycle(B)) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready),
            .in_i       (din),
`ifdef SUBBYTES_INV_EN
            .inv_i      (inv),
`endif
            .out_valid_o(out_valid),
            .out_ready_i(out_ready),
            .out_o      (dout)
        );

        function automatic void chk(input string n, input logic [127:0] a,
                                    input logic [127:0] e);
            check($sformatf("B%0d_%s", B, n), a, e);
        endfunction

        initial forever begin
            @(posedge clk);
            cyc++;
        end

        initial forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end

        // Monitor: values seen at negedge are what the next rising edge acts on.
        initial forever begin
            @(negedge clk);
            if (!rst) begin
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", dout, held);
                    if (!out_ready) chk("hold_in_ready", in_ready, 0);
                end
                hold = out_valid && !out_ready;
                held = dout;
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_valid", out_valid, 0);
                    end else begin
                        if (!seen) begin
                            chk("latency", cyc - sb_q[0].acc, N);
                            seen = 1;
                        end
                        if (out_ready) begin
                            chk("data", dout, sb_q[0].exp);
                            void'(sb_q.pop_front());
                            seen = 0;
                        end
                    end
                end
            end
        end

        task automatic send(input logic [127:0] d, input logic [127:0] e, input logic iv,
                            output int waited);
            bit got = 0;
            waited   = 0;
            in_valid = 1'b1;
            din      = d;
            inv      = iv;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                if (in_ready) begin
                    got = 1;
                    sb_q.push_back('{exp: e, acc: cyc + 1});
                end else begin
                    waited++;
                end
            end
            if (!got) chk("accept_timeout", 0, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            din      = rnd128();
            inv      = 1'($urandom_range(0, 1));
        endtask

        task automatic apply_reset();
            rst = 1'b1;
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out", dout, 0);
            chk("rst_in_ready", in_ready, 1);
            sb_q.delete();
            seen     = 0;
            hold     = 0;
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        endtask

        task automatic drain();
            for (int t = 0; t < 400 && sb_q.size() != 0; t++) @(posedge clk);
            chk("drain", sb_q.size(), 0);
            #1;
        endtask

        initial begin
            logic [127:0] r;
            int           w;
            rst       = 1'b1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            inv       = 1'b0;
            din       = '0;
            wait (tables_ready);
            @(posedge clk);
            #2;
            apply_reset();

            // Reset two cycles after accept discards the partial result.
            r = rnd128();
            send(r, subst(r, 0), 0, w);
            repeat (2) @(posedge clk);
            #2;
            apply_reset();

            send('0, {16{8'h63}}, 0, w);
            send(FipsIn, FipsOut, 0, w);
            drain();

            // Backpressure, then retire and capture on the same edge.
            out_ready = 1'b0;
            r = rnd128();
            send(r, subst(r, 0), 0, w);
            repeat (N + 10) @(posedge clk);
            #1;
            out_ready = 1'b1;
            r = rnd128();
            send(r, subst(r, 0), 0, w);
            chk("same_edge_accept", w, 0);
            drain();

            for (int i = 0; i < 8; i++) begin
                r = rnd128();
                send(r, subst(r, 0), 0, w);
            end
            drain();

            rand_rdy = 1;
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                r = rnd128();
                send(r, subst(r, 0), 0, w);
            end
            rand_rdy = 0;
            out_ready = 1'b1;
            drain();

`ifdef SUBBYTES_INV_EN
            send({16{8'h63}}, '0, 1, w);
            r = {rnd128() >> 8, 8'hed};
            send(r, subst(r, 1), 1, w);
            send(FipsOut, FipsIn, 1, w);
            for (int i = 0; i < 6; i++) begin
                logic iv;
                iv = 1'($urandom_range(0, 1));
                r  = rnd128();
                send(r, subst(r, iv), iv, w);
            end
            drain();
`endif
            done_cnt = done_cnt + 1;
        end
    end

    initial begin
        wait (done_cnt == 5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
